// File: rtl/axi_read_reorder_buffer_pkg.sv
// Shared definitions for the AXI read reorder buffer.
// Purpose : default build parameters, plus pointer, index and entry types for that
//           default configuration. Modules take their own parameters, which default
//           to the values here, and derive matching local types from them.
// Ports   : none (package).
package rob_pkg;

    localparam int ROB_DATA_WIDTH = 8;
    localparam int ROB_ID_WIDTH   = 4;
    localparam int ROB_DEPTH      = 8;
    localparam int ROB_IDX_W      = $clog2(ROB_DEPTH);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    typedef logic [ROB_IDX_W:0]   ptr_t;
    typedef logic [ROB_IDX_W-1:0] idx_t;

    typedef struct packed {
        logic                      valid;
        logic                      filled;
        logic [ROB_ID_WIDTH-1:0]   id;
        logic [ROB_DATA_WIDTH-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/axi_read_reorder_buffer_if.sv
// Bus bundle for the AXI read reorder buffer.
// Purpose : groups the slave-side AR/R channel, the master-side AR/R channel and the
//           status outputs (count, sticky error).
// Ports   : slave modport  - view from the reorder buffer itself.
//           master modport - view from the surrounding requester/memory (or a bench).
interface axi_read_reorder_buffer_if
    import rob_pkg::*;
#(
    parameter int DATA_WIDTH = ROB_DATA_WIDTH,
    parameter int ID_WIDTH   = ROB_ID_WIDTH,
    parameter int DEPTH      = ROB_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ID_WIDTH-1:0]   s_arid_i;
    logic                  s_arvalid_i;
    logic                  s_arready_o;
    logic [DATA_WIDTH-1:0] s_rdata_o;
    logic [ID_WIDTH-1:0]   s_rid_o;
    logic                  s_rvalid_o;
    logic                  s_rready_i;
    logic [ID_WIDTH-1:0]   m_arid_o;
    logic                  m_arvalid_o;
    logic                  m_arready_i;
    logic [DATA_WIDTH-1:0] m_rdata_i;
    logic [ID_WIDTH-1:0]   m_rid_i;
    logic                  m_rvalid_i;
    logic                  m_rready_o;
    logic [CW-1:0]         count_o;
    logic                  err_unexpected_o;

    modport slave (
        input  s_arid_i, s_arvalid_i, s_rready_i,
        input  m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
        output s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o,
        output m_arid_o, m_arvalid_o, m_rready_o,
        output count_o, err_unexpected_o
    );

    modport master (
        output s_arid_i, s_arvalid_i, s_rready_i,
        output m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
        input  s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o,
        input  m_arid_o, m_arvalid_o, m_rready_o,
        input  count_o, err_unexpected_o
    );

endinterface

// File: rtl/axi_read_reorder_buffer_oldest_match.sv
// Age-ordered ID search over the reorder buffer entries.
// Purpose : find the oldest entry (starting at head and walking forward in issue
//           order) that is valid, still waiting for data, and carries the given ID.
// Ports   : i_valid/i_filled/i_ids - per-entry state, i_head - head index,
//           i_id - ID to look up, o_hit - a match exists, o_idx - index of the match.
module rob_oldest_match
    import rob_pkg::*;
#(
    parameter int ID_WIDTH = ROB_ID_WIDTH,
    parameter int DEPTH    = ROB_DEPTH
) (
    input  logic [DEPTH-1:0]               i_valid,
    input  logic [DEPTH-1:0]               i_filled,
    input  logic [DEPTH-1:0][ID_WIDTH-1:0] i_ids,
    input  logic [$clog2(DEPTH)-1:0]       i_head,
    input  logic [ID_WIDTH-1:0]            i_id,
    output logic                           o_hit,
    output logic [$clog2(DEPTH)-1:0]       o_idx
);
    localparam int IW = $clog2(DEPTH);

    logic [IW-1:0] w_pos;

    // Walk from youngest to oldest so the oldest match is the last one written.
    // Index arithmetic wraps for free because DEPTH is a power of two.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        w_pos = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_pos = i_head + IW'(k);
            if (i_valid[w_pos] && !i_filled[w_pos] && (i_ids[w_pos] == i_id)) begin
                o_hit = 1'b1;
                o_idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/axi_read_reorder_buffer.sv
// AXI read reorder buffer.
// Purpose : forwards AR requests to the master side, records them in issue order and
//           re-emits single-beat R responses strictly in that order, whatever order
//           the master returns them in. Repeated IDs match oldest-first.
// Ports   : clk, rst_n (async, active low), bus (slave modport: s_ar*/s_r* requester
//           side, m_ar*/m_r* memory side, count_o occupancy, err_unexpected_o sticky).
module axi_read_reorder_buffer
    import rob_pkg::*;
#(
    parameter int DATA_WIDTH = ROB_DATA_WIDTH,
    parameter int ID_WIDTH   = ROB_ID_WIDTH,
    parameter int DEPTH      = ROB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_read_reorder_buffer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                  valid;
        logic                  filled;
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t       r_entry [DEPTH];
    logic [IW:0]  r_head;
    logic [IW:0]  r_tail;
    logic         r_err;

    logic [IW-1:0]                  w_head_idx;
    logic [IW-1:0]                  w_tail_idx;
    logic                           w_full;
    logic                           w_ar_fire;
    logic                           w_out_valid;
    logic                           w_release;
    logic [DEPTH-1:0]               w_valid_vec;
    logic [DEPTH-1:0]               w_filled_vec;
    logic [DEPTH-1:0][ID_WIDTH-1:0] w_id_vec;
    logic                           w_hit;
    logic [IW-1:0]                  w_hit_idx;

    assign w_head_idx = r_head[IW-1:0];
    assign w_tail_idx = r_tail[IW-1:0];
    assign w_full     = (r_head[IW] != r_tail[IW]) && (w_head_idx == w_tail_idx);

    // rst_n gates the AR handshake directly so nothing is accepted while held in reset.
    assign bus.m_arid_o    = bus.s_arid_i;
    assign bus.m_arvalid_o = bus.s_arvalid_i & ~w_full & rst_n;
    assign bus.s_arready_o = bus.m_arready_i & ~w_full & rst_n;
    assign w_ar_fire       = bus.s_arvalid_i & bus.s_arready_o;

    // Every outstanding read already owns an entry, so R beats never need backpressure.
    assign bus.m_rready_o  = 1'b1;

    assign w_out_valid      = r_entry[w_head_idx].valid & r_entry[w_head_idx].filled;
    assign w_release        = w_out_valid & bus.s_rready_i;
    assign bus.s_rvalid_o   = w_out_valid;
    assign bus.s_rdata_o    = w_out_valid ? r_entry[w_head_idx].data : '0;
    assign bus.s_rid_o      = w_out_valid ? r_entry[w_head_idx].id : '0;
    assign bus.count_o      = r_tail - r_head;
    assign bus.err_unexpected_o = r_err;

    always_comb begin
        w_valid_vec  = '0;
        w_filled_vec = '0;
        w_id_vec     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_vec[i]  = r_entry[i].valid;
            w_filled_vec[i] = r_entry[i].filled;
            w_id_vec[i]     = r_entry[i].id;
        end
    end

    rob_oldest_match #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH)
    ) u_match (
        .i_valid  (w_valid_vec),
        .i_filled (w_filled_vec),
        .i_ids    (w_id_vec),
        .i_head   (w_head_idx),
        .i_id     (bus.m_rid_i),
        .o_hit    (w_hit),
        .o_idx    (w_hit_idx)
    );

    // Release, allocate and fill always touch different entries in the same cycle:
    // the released head is already filled, and the slot at tail is invalid pre-edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_release) begin
                r_entry[w_head_idx].valid  <= 1'b0;
                r_entry[w_head_idx].filled <= 1'b0;
                r_head <= r_head + CW'(1);
            end
            if (w_ar_fire) begin
                r_entry[w_tail_idx].valid  <= 1'b1;
                r_entry[w_tail_idx].filled <= 1'b0;
                r_entry[w_tail_idx].id     <= bus.s_arid_i;
                r_entry[w_tail_idx].data   <= '0;
                r_tail <= r_tail + CW'(1);
            end
            if (bus.m_rvalid_i) begin
                if (w_hit) begin
                    r_entry[w_hit_idx].data   <= bus.m_rdata_i;
                    r_entry[w_hit_idx].filled <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_read_reorder_buffer.sv
// Testbench for axi_read_reorder_buffer.
// Purpose : directed table of cycle vectors, hand-written full/reset sequences, and a
//           randomized run compared each cycle against a queue-based model of the
//           issue-order reply stream.
// Ports   : none (top-level bench).
module tb_axi_read_reorder_buffer;
    import rob_pkg::*;

    localparam int DW    = 8;
    localparam int IDW   = 4;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_read_reorder_buffer_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEPTH(DEPTH)) bus ();

    axi_read_reorder_buffer #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    bit last_arready;

    // Reference model: outstanding reads in issue order.
    logic [IDW-1:0] q_id  [$];
    logic [DW-1:0]  q_dat [$];
    bit             q_fil [$];
    bit             mdl_err;

    typedef struct {
        bit             arv;
        logic [IDW-1:0] arid;
        bit             rv;
        logic [IDW-1:0] rid;
        logic [DW-1:0]  rd;
        bit             rr;
        bit             ev;
        logic [IDW-1:0] eid;
        logic [DW-1:0]  ed;
        int             ecnt;
        bit             eerr;
    } vec_t;

    vec_t tv [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_clear();
        q_id.delete();
        q_dat.delete();
        q_fil.delete();
        mdl_err = 1'b0;
    endtask

    task automatic drive_idle();
        bus.s_arvalid_i = 1'b0;
        bus.s_arid_i    = '0;
        bus.m_arready_i = 1'b1;
        bus.m_rvalid_i  = 1'b0;
        bus.m_rid_i     = '0;
        bus.m_rdata_i   = '0;
        bus.s_rready_i  = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_v;
        exp_v = (q_id.size() > 0) && q_fil[0];
        chk("s_rvalid", bus.s_rvalid_o, exp_v);
        chk("s_rid", bus.s_rid_o, exp_v ? q_id[0] : '0);
        chk("s_rdata", bus.s_rdata_o, exp_v ? q_dat[0] : '0);
        chk("count", bus.count_o, q_id.size());
        chk("err", bus.err_unexpected_o, mdl_err);
    endtask

    // One clock cycle: called 1 time unit after a rising edge, returns 1 after the next.
    task automatic step(input bit arv, input logic [IDW-1:0] arid, input bit mar,
                        input bit rv, input logic [IDW-1:0] rid, input logic [DW-1:0] rd,
                        input bit rr);
        bit full, exp_ar, fire, rel;
        int hit;
        bus.s_arvalid_i = arv;
        bus.s_arid_i    = arid;
        bus.m_arready_i = mar;
        bus.m_rvalid_i  = rv;
        bus.m_rid_i     = rid;
        bus.m_rdata_i   = rd;
        bus.s_rready_i  = rr;
        #1;
        full   = (q_id.size() == DEPTH);
        exp_ar = mar && !full;
        last_arready = bus.s_arready_o;
        chk("s_arready", bus.s_arready_o, exp_ar);
        chk("m_arvalid", bus.m_arvalid_o, arv && !full);
        chk("m_arid", bus.m_arid_o, arid);
        chk("m_rready", bus.m_rready_o, 1);
        fire = arv && exp_ar;
        rel  = (q_id.size() > 0) && q_fil[0] && rr;
        hit  = -1;
        if (rv) begin
            for (int k = 0; k < q_id.size(); k++) begin
                if (hit < 0 && !q_fil[k] && q_id[k] == rid) hit = k;
            end
        end
        @(posedge clk);
        cyc++;
        if (rv) begin
            if (hit >= 0) begin
                q_dat[hit] = rd;
                q_fil[hit] = 1'b1;
            end else begin
                mdl_err = 1'b1;
            end
        end
        if (rel) begin
            void'(q_id.pop_front());
            void'(q_dat.pop_front());
            void'(q_fil.pop_front());
        end
        if (fire) begin
            q_id.push_back(arid);
            q_dat.push_back('0);
            q_fil.push_back(1'b0);
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, with AR valid/ready driven high to prove reset gating.
        drive_idle();
        bus.s_arvalid_i = 1'b1;
        model_clear();
        #2;
        chk("rst_s_arready", bus.s_arready_o, 0);
        chk("rst_m_arvalid", bus.m_arvalid_o, 0);
        chk("rst_s_rvalid", bus.s_rvalid_o, 0);
        chk("rst_s_rdata", bus.s_rdata_o, 0);
        chk("rst_s_rid", bus.s_rid_o, 0);
        chk("rst_m_rready", bus.m_rready_o, 1);
        chk("rst_count", bus.count_o, 0);
        chk("rst_err", bus.err_unexpected_o, 0);
        bus.s_arvalid_i = 1'b0;
        #8;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // In-order, reorder, duplicate ID, unexpected ID.
        tv[0]  = '{1, 1, 0, 0, 8'h00, 0,  0, 0, 8'h00, 1, 0};
        tv[1]  = '{1, 2, 0, 0, 8'h00, 0,  0, 0, 8'h00, 2, 0};
        tv[2]  = '{1, 3, 0, 0, 8'h00, 0,  0, 0, 8'h00, 3, 0};
        tv[3]  = '{0, 0, 1, 1, 8'hA1, 0,  1, 1, 8'hA1, 3, 0};
        tv[4]  = '{0, 0, 1, 2, 8'hA2, 1,  1, 2, 8'hA2, 2, 0};
        tv[5]  = '{0, 0, 1, 3, 8'hA3, 1,  1, 3, 8'hA3, 1, 0};
        tv[6]  = '{0, 0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0};
        tv[7]  = '{1, 4, 0, 0, 8'h00, 0,  0, 0, 8'h00, 1, 0};
        tv[8]  = '{1, 5, 0, 0, 8'h00, 0,  0, 0, 8'h00, 2, 0};
        tv[9]  = '{1, 6, 0, 0, 8'h00, 0,  0, 0, 8'h00, 3, 0};
        tv[10] = '{0, 0, 1, 6, 8'h66, 1,  0, 0, 8'h00, 3, 0};
        tv[11] = '{0, 0, 1, 4, 8'h44, 1,  1, 4, 8'h44, 3, 0};
        tv[12] = '{0, 0, 1, 5, 8'h55, 1,  1, 5, 8'h55, 2, 0};
        tv[13] = '{0, 0, 0, 0, 8'h00, 1,  1, 6, 8'h66, 1, 0};
        tv[14] = '{0, 0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0};
        tv[15] = '{1, 7, 0, 0, 8'h00, 0,  0, 0, 8'h00, 1, 0};
        tv[16] = '{1, 7, 0, 0, 8'h00, 0,  0, 0, 8'h00, 2, 0};
        tv[17] = '{0, 0, 1, 7, 8'h01, 0,  1, 7, 8'h01, 2, 0};
        tv[18] = '{0, 0, 1, 7, 8'h02, 1,  1, 7, 8'h02, 1, 0};
        tv[19] = '{0, 0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 0, 0};
        tv[20] = '{0, 0, 1, 15, 8'h5A, 1, 0, 0, 8'h00, 0, 1};

        for (int i = 0; i < 21; i++) begin
            step(tv[i].arv, tv[i].arid, 1'b1, tv[i].rv, tv[i].rid, tv[i].rd, tv[i].rr);
            chk("tbl_rvalid", bus.s_rvalid_o, tv[i].ev);
            chk("tbl_rid", bus.s_rid_o, tv[i].eid);
            chk("tbl_rdata", bus.s_rdata_o, tv[i].ed);
            chk("tbl_count", bus.count_o, tv[i].ecnt);
            chk("tbl_err", bus.err_unexpected_o, tv[i].eerr);
        end

        // Full: eight accepted, ninth stalls until a head handshake frees a slot.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, IDW'(i), 1'b1, 1'b0, '0, '0, 1'b0);
            chk("full_fill_arready", last_arready, 1);
        end
        chk("full_count8", bus.count_o, 8);
        step(1'b1, 4'h9, 1'b1, 1'b1, 4'h0, 8'h10, 1'b0);
        chk("full_9th_stall", last_arready, 0);
        chk("full_count_hold", bus.count_o, 8);
        step(1'b1, 4'h9, 1'b1, 1'b0, '0, '0, 1'b1);
        chk("full_stall_on_release", last_arready, 0);
        chk("full_count7", bus.count_o, 7);
        step(1'b1, 4'h9, 1'b1, 1'b0, '0, '0, 1'b0);
        chk("full_9th_accept", last_arready, 1);
        chk("full_count_back8", bus.count_o, 8);

        // Reset mid-operation, then a late beat flags the error.
        do_reset();
        step(1'b1, 4'h1, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 4'h2, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 4'h3, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 8'hB1, 1'b0);
        chk("mid_pre_rvalid", bus.s_rvalid_o, 1);
        bus.s_arvalid_i = 1'b1;
        bus.m_arready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_s_arready", bus.s_arready_o, 0);
        chk("mid_m_arvalid", bus.m_arvalid_o, 0);
        chk("mid_s_rvalid", bus.s_rvalid_o, 0);
        chk("mid_s_rdata", bus.s_rdata_o, 0);
        chk("mid_s_rid", bus.s_rid_o, 0);
        chk("mid_m_rready", bus.m_rready_o, 1);
        chk("mid_count", bus.count_o, 0);
        chk("mid_err", bus.err_unexpected_o, 0);
        drive_idle();
        model_clear();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 8'hC2, 1'b0);
        chk("late_beat_err", bus.err_unexpected_o, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit             arv, mar, rv, rr;
            logic [IDW-1:0] arid, rid;
            logic [DW-1:0]  rd;
            int             cand [$];
            arv  = ($urandom_range(0, 2) != 0);
            arid = IDW'($urandom_range(0, 3));
            mar  = ($urandom_range(0, 3) != 0);
            rr   = ($urandom_range(0, 3) != 0);
            rd   = DW'($urandom_range(0, 255));
            rv   = 1'b0;
            rid  = '0;
            cand.delete();
            for (int k = 0; k < q_id.size(); k++) begin
                if (!q_fil[k]) cand.push_back(k);
            end
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                rv  = 1'b1;
                rid = q_id[cand[$urandom_range(0, cand.size() - 1)]];
            end else if ($urandom_range(0, 39) == 0) begin
                rv  = 1'b1;
                rid = IDW'($urandom_range(8, 15));
            end
            step(arv, arid, mar, rv, rid, rd, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
